// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the read-master state type.
// Imported by the read initiator and by sibling AXI blocks.
package axi_pkg;

    localparam logic [1:0] FIXED  = 2'd0;
    localparam logic [1:0] INCR   = 2'd1;
    localparam logic [1:0] WRAP   = 2'd2;

    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] EXOKAY = 2'd1;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } rd_state_t;

endpackage

// File: rtl/axi_rd_out_reg.sv
// One-entry valid/ready register for {data, resp, last}; accepts a new entry
// in the same cycle the old one drains, so it sustains one transfer per cycle.
module axi_rd_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_resp,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_resp,
    output logic                  out_last
);

    assign in_ready = !out_valid || out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the payload is reset too, so outputs read as zero after reset
            // rather than carrying stale data from an aborted burst.
            out_valid <= 1'b0;
            out_data  <= '0;
            out_resp  <= '0;
            out_last  <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_resp  <= in_resp;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_read_master.sv
// AXI4 read initiator: issues one burst per command, forwards R beats through
// a one-entry output register and reports per-burst status on a done pulse.
module axi_read_master
    import axi_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [7:0]               cmd_len,
    input  logic [2:0]               cmd_size,
    input  logic [1:0]               cmd_burst,
    output logic [ADDRESS_WIDTH-1:0] araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [1:0]               out_resp,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     done,
    output logic                     done_resp_err,
    output logic                     done_len_err
);

    rd_state_t  state_q, state_d;
    logic [7:0] beat_cnt;
    logic       resp_err, len_err;
    logic       buf_ready;
    logic       beat_accept;
    logic       last_beat;
    logic       cmd_fire;

    assign last_beat   = (beat_cnt == arlen);
    assign rready      = (state_q == DATA) && buf_ready;
    assign beat_accept = rvalid && rready;
    assign cmd_fire    = cmd_valid && cmd_ready;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = !areset;
                if (cmd_valid && !areset) state_d = ADDR;
            end
            ADDR:    if (arvalid && arready) state_d = DATA;
            DATA:    if (beat_accept && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            araddr        <= '0;
            arlen         <= '0;
            arsize        <= '0;
            arburst       <= '0;
            arvalid       <= 1'b0;
            beat_cnt      <= '0;
            resp_err      <= 1'b0;
            len_err       <= 1'b0;
            done          <= 1'b0;
            done_resp_err <= 1'b0;
            done_len_err  <= 1'b0;
        end else begin
            done          <= 1'b0;
            done_resp_err <= 1'b0;
            done_len_err  <= 1'b0;
            if (cmd_fire) begin
                araddr   <= cmd_addr;
                arlen    <= cmd_len;
                arsize   <= cmd_size;
                arburst  <= cmd_burst;
                arvalid  <= 1'b1;
                beat_cnt <= '0;
                resp_err <= 1'b0;
                len_err  <= 1'b0;
            end
            if (arvalid && arready) arvalid <= 1'b0;
            // Termination is by count; a stray rlast only raises len_err.
            if (beat_accept) begin
                beat_cnt <= beat_cnt + 8'd1;
                resp_err <= resp_err | rresp[1];
                len_err  <= len_err | (rlast != last_beat);
                if (last_beat) begin
                    done          <= 1'b1;
                    done_resp_err <= resp_err | rresp[1];
                    done_len_err  <= len_err | (rlast != last_beat);
                end
            end
        end
    end

    axi_rd_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk       (aclk),
        .reset     (areset),
        .in_valid  (rvalid && (state_q == DATA)),
        .in_ready  (buf_ready),
        .in_data   (rdata),
        .in_resp   (rresp),
        .in_last   (last_beat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_resp  (out_resp),
        .out_last  (out_last)
    );

endmodule
